// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg: state/cause encodings and reset PC shared with the fetch buffer
package fetch_redirect_ctrl_pkg;
    typedef enum logic [2:0] {RUN, FLUSH, DRAIN, HALT, REDIRECT} state_t;
    typedef enum logic [2:0] {CAUSE_EXCP, CAUSE_ERTN, CAUSE_REFETCH, CAUSE_IDLE, CAUSE_BR} cause_t;
    localparam logic [31:0] PC_RESET = 32'h1c000000;
endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: backend redirect requests in, fetch-side flush/stall/redirect out
interface fetch_redirect_ctrl_if;
    logic        wb_excp_valid;
    logic [31:0] wb_excp_pc;
    logic        wb_ertn_valid;
    logic [31:0] wb_ertn_pc;
    logic        wb_refetch_valid;
    logic [31:0] wb_refetch_pc;
    logic        wb_idle_valid;
    logic [31:0] wb_idle_pc;
    logic        ex_br_valid;
    logic [31:0] ex_br_target;
    logic        intr_pending;
    logic        backend_empty;
    logic        if_redirect_ready;
    logic        fifo_flush;
    logic        if_flush;
    logic        fetch_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ctrl_busy;
    modport master (
        output wb_excp_valid, wb_excp_pc, wb_ertn_valid, wb_ertn_pc, wb_refetch_valid, wb_refetch_pc,
               wb_idle_valid, wb_idle_pc, ex_br_valid, ex_br_target, intr_pending, backend_empty,
               if_redirect_ready,
        input  fifo_flush, if_flush, fetch_stall, redirect_valid, redirect_pc, ctrl_busy
    );
    modport slave (
        input  wb_excp_valid, wb_excp_pc, wb_ertn_valid, wb_ertn_pc, wb_refetch_valid, wb_refetch_pc,
               wb_idle_valid, wb_idle_pc, ex_br_valid, ex_br_target, intr_pending, backend_empty,
               if_redirect_ready,
        output fifo_flush, if_flush, fetch_stall, redirect_valid, redirect_pc, ctrl_busy
    );
endinterface

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
// redirect_prio_sel: program-order priority pick among redirect sources (excp > ertn > refetch > idle > br)
module redirect_prio_sel
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic        excp_valid,
    input  logic [31:0] excp_pc,
    input  logic        ertn_valid,
    input  logic [31:0] ertn_pc,
    input  logic        refetch_valid,
    input  logic [31:0] refetch_pc,
    input  logic        idle_valid,
    input  logic [31:0] idle_pc,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    output logic        any_valid,
    output cause_t      cause,
    output logic [31:0] target
);
    always_comb begin
        any_valid = excp_valid | ertn_valid | refetch_valid | idle_valid | br_valid;
        cause     = excp_valid ? CAUSE_EXCP : ertn_valid ? CAUSE_ERTN :
                    refetch_valid ? CAUSE_REFETCH : idle_valid ? CAUSE_IDLE : CAUSE_BR;
        target    = excp_valid ? excp_pc : ertn_valid ? ertn_pc :
                    refetch_valid ? refetch_pc : idle_valid ? idle_pc : br_pc;
    end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates backend redirects into fetch flush/stall and a held redirect PC.
// Optional FETCH_REDIRECT_STAT_EN adds saturating flush/stall statistics outputs.
module fetch_redirect_ctrl #(
    parameter logic [31:0] PC_RESET     = fetch_redirect_ctrl_pkg::PC_RESET,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_redirect_ctrl_if.slave  bus
`ifdef FETCH_REDIRECT_STAT_EN
    ,
    output logic [31:0]           stat_br_flush,
    output logic [31:0]           stat_wb_flush,
    output logic [31:0]           stat_stall_cycles
`endif
);
    import fetch_redirect_ctrl_pkg::*;

    state_t            state, state_n;
    cause_t            cause, cause_n, sel_cause;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       pc_n, sel_target;
    logic              sel_valid, run;

    assign run = state == RUN;

    // Only excp/ertn may preempt an in-progress sequence
    redirect_prio_sel u_sel (
        .excp_valid    (bus.wb_excp_valid),
        .excp_pc       (bus.wb_excp_pc),
        .ertn_valid    (bus.wb_ertn_valid),
        .ertn_pc       (bus.wb_ertn_pc),
        .refetch_valid (bus.wb_refetch_valid & run),
        .refetch_pc    (bus.wb_refetch_pc),
        .idle_valid    (bus.wb_idle_valid & run),
        .idle_pc       (bus.wb_idle_pc),
        .br_valid      (bus.ex_br_valid & run),
        .br_pc         (bus.ex_br_target),
        .any_valid     (sel_valid),
        .cause         (sel_cause),
        .target        (sel_target)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cause_n = cause;
        pc_n    = bus.redirect_pc;
        if (sel_valid) begin
            state_n = FLUSH;
            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
            cause_n = sel_cause;
            pc_n    = sel_target;
        end else begin
            case (state)
                FLUSH: begin
                    cnt_n = (cnt == '0) ? cnt : cnt - CNT_W'(1);
                    if (cnt == '0)
                        state_n = (cause == CAUSE_REFETCH) ? DRAIN : (cause == CAUSE_IDLE) ? HALT : REDIRECT;
                end
                DRAIN:    state_n = bus.backend_empty ? REDIRECT : DRAIN;
                HALT:     state_n = bus.intr_pending ? REDIRECT : HALT;
                REDIRECT: state_n = bus.if_redirect_ready ? RUN : REDIRECT;
                default:  state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= RUN;
            cause              <= CAUSE_BR;
            cnt                <= '0;
            bus.fifo_flush     <= 1'b0;
            bus.if_flush       <= 1'b0;
            bus.fetch_stall    <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.ctrl_busy      <= 1'b0;
            bus.redirect_pc    <= PC_RESET;
        end else begin
            state              <= state_n;
            cause              <= cause_n;
            cnt                <= cnt_n;
            bus.fifo_flush     <= sel_valid;
            bus.if_flush       <= state_n == FLUSH;
            bus.fetch_stall    <= state_n != RUN;
            bus.redirect_valid <= state_n == REDIRECT;
            bus.ctrl_busy      <= state_n != RUN;
            bus.redirect_pc    <= pc_n;
        end
    end

`ifdef FETCH_REDIRECT_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_flush     <= '0;
            stat_wb_flush     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (sel_valid && sel_cause == CAUSE_BR && stat_br_flush != '1)
                stat_br_flush <= stat_br_flush + 32'd1;
            if (sel_valid && sel_cause != CAUSE_BR && stat_wb_flush != '1)
                stat_wb_flush <= stat_wb_flush + 32'd1;
            if (bus.fetch_stall && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif
endmodule
